// File: rtl/nf_tx_arbiter_pkg.sv
// Shared definitions for the 10G TX arbiter: FSM encodings and the abort-beat constants.
package nf_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_ABORT = 2'd2
    } arbState_e;

    localparam logic [7:0]  ABORT_TKEEP = 8'h01;
    localparam logic [63:0] ABORT_TDATA = 64'h0;

    function automatic logic [15:0] satInc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/nf_tx_arbiter_rr_pick.sv
// Combinational cyclic priority picker: first request at or after ptr_i wins.
// Also used by the RX demux, so it carries no arbiter-specific state.
module nf_rr_pick #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic          valid_o
);

    logic [PW-1:0] idx;

    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr_i) + k) % N);
            if (!valid_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                valid_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nf_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of the 10G MAC TX stream.
// A granted source that stalls mid-frame is cut off with an error beat and its remainder drained.
module nf_tx_arbiter
    import nf_tx_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 32
) (
    input  logic                     clk156,
    input  logic                     reset,
    input  logic [64*NUM_SRC-1:0]    src_tdata,
    input  logic [8*NUM_SRC-1:0]     src_tkeep,
    input  logic [NUM_SRC-1:0]       src_tlast,
    input  logic [NUM_SRC-1:0]       src_tvalid,
    output logic [NUM_SRC-1:0]       src_tready,
    output logic [63:0]              tx_tdata,
    output logic [7:0]               tx_tkeep,
    output logic                     tx_tlast,
    output logic                     tx_tuser,
    output logic                     tx_tvalid,
    input  logic                     tx_tready,
    output logic [NUM_SRC-1:0]       grant,
    output logic [CNT_W*NUM_SRC-1:0] pkt_cnt,
    output logic [15:0]              abort_cnt
);

    localparam int PW = $clog2(NUM_SRC);
    localparam int SW = $clog2(TIMEOUT) + 1;

    arbState_e          state_q, state_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [PW-1:0]      gIdx_q, gIdx_d;
    logic [PW-1:0]      rrPtr_q, rrPtr_d;
    logic [NUM_SRC-1:0] drainMask_q, drainMask_d;
    logic [SW-1:0]      stall_q, stall_d;
    logic [CNT_W-1:0]   pktCnt_q [NUM_SRC];
    logic [15:0]        abortCnt_q, abortCnt_d;

    logic [NUM_SRC-1:0] pickGnt;
    logic               pickValid;
    logic [PW-1:0]      pickIdx;
    logic [PW-1:0]      nextPtr;
    logic               pktDone;
    logic               abortDone;

    // Draining sources are invisible to arbitration until their frame tail has been discarded.
    nf_rr_pick #(.N(NUM_SRC), .PW(PW)) u_pick (
        .req_i   (src_tvalid & ~drainMask_q),
        .ptr_i   (rrPtr_q),
        .gnt_o   (pickGnt),
        .valid_o (pickValid)
    );

    always_comb begin
        pickIdx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pickGnt[i]) pickIdx = PW'(i);
        end
    end

    assign nextPtr    = (gIdx_q == PW'(NUM_SRC - 1)) ? '0 : gIdx_q + 1'b1;
    assign abortCnt_d = satInc16(abortCnt_q);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gIdx_d     = gIdx_q;
        rrPtr_d    = rrPtr_q;
        stall_d    = stall_q;
        pktDone    = 1'b0;
        abortDone  = 1'b0;
        tx_tdata   = '0;
        tx_tkeep   = '0;
        tx_tlast   = 1'b0;
        tx_tuser   = 1'b0;
        tx_tvalid  = 1'b0;
        src_tready = drainMask_q;
        case (state_q)
            ST_IDLE: begin
                stall_d = '0;
                if (pickValid) begin
                    grant_d = pickGnt;
                    gIdx_d  = pickIdx;
                    state_d = ST_PASS;
                end
            end
            ST_PASS: begin
                tx_tdata           = src_tdata[64*gIdx_q +: 64];
                tx_tkeep           = src_tkeep[8*gIdx_q +: 8];
                tx_tlast           = src_tlast[gIdx_q];
                tx_tvalid          = src_tvalid[gIdx_q];
                src_tready[gIdx_q] = tx_tready;
                // A beat in this cycle means the source is alive, so tlast always beats the timeout.
                if (tx_tvalid && tx_tready) begin
                    stall_d = '0;
                    if (tx_tlast) begin
                        pktDone = 1'b1;
                        rrPtr_d = nextPtr;
                        grant_d = '0;
                        state_d = ST_IDLE;
                    end
                end else if (src_tvalid[gIdx_q]) begin
                    stall_d = '0;
                end else if (stall_q == SW'(TIMEOUT - 1)) begin
                    state_d = ST_ABORT;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
            end
            ST_ABORT: begin
                tx_tvalid = 1'b1;
                tx_tdata  = ABORT_TDATA;
                tx_tkeep  = ABORT_TKEEP;
                tx_tlast  = 1'b1;
                tx_tuser  = 1'b1;
                if (tx_tready) begin
                    abortDone = 1'b1;
                    rrPtr_d   = nextPtr;
                    grant_d   = '0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Completion uses the registered mask, so a finishing source can only re-request next cycle.
    always_comb begin
        drainMask_d = drainMask_q & ~(src_tvalid & src_tlast);
        if (abortDone) drainMask_d = drainMask_d | grant_q;
    end

    always_ff @(posedge clk156) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            gIdx_q      <= '0;
            rrPtr_q     <= '0;
            drainMask_q <= '0;
            stall_q     <= '0;
            abortCnt_q  <= '0;
            for (int i = 0; i < NUM_SRC; i++) pktCnt_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gIdx_q      <= gIdx_d;
            rrPtr_q     <= rrPtr_d;
            drainMask_q <= drainMask_d;
            stall_q     <= stall_d;
            if (pktDone) pktCnt_q[gIdx_q] <= pktCnt_q[gIdx_q] + 1'b1;
            if (abortDone) abortCnt_q <= abortCnt_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) pkt_cnt[CNT_W*i +: CNT_W] = pktCnt_q[i];
    end

    assign grant     = grant_q;
    assign abort_cnt = abortCnt_q;

endmodule

// File: tb/tb_nf_tx_arbiter.sv
// Scoreboard bench for nf_tx_arbiter: two queued packet sources, expected MAC beats in a queue,
// and a negedge monitor that pops and compares every beat the MAC accepts.
module tb_nf_tx_arbiter;

    localparam int NUM_SRC = 2;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 32;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        int          stall;
    } srcBeat_t;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
        logic [1:0]  grant;
        int          gap;
    } expBeat_t;

    logic                     clk156 = 1'b0;
    logic                     reset = 1'b1;
    logic [64*NUM_SRC-1:0]    src_tdata = '0;
    logic [8*NUM_SRC-1:0]     src_tkeep = '0;
    logic [NUM_SRC-1:0]       src_tlast = '0;
    logic [NUM_SRC-1:0]       src_tvalid = '0;
    logic [NUM_SRC-1:0]       src_tready;
    logic [63:0]              tx_tdata;
    logic [7:0]               tx_tkeep;
    logic                     tx_tlast;
    logic                     tx_tuser;
    logic                     tx_tvalid;
    logic                     tx_tready = 1'b1;
    logic [NUM_SRC-1:0]       grant;
    logic [CNT_W*NUM_SRC-1:0] pkt_cnt;
    logic [15:0]              abort_cnt;

    srcBeat_t    q0[$];
    srcBeat_t    q1[$];
    expBeat_t    expQ[$];
    logic [1:0]  srcAcc = '0;
    int          wait0 = 0;
    int          wait1 = 0;
    int          popCnt0 = 0;
    bit          toggleMode = 1'b0;
    bit          stimDone = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          expPkt [2];
    int          expAbort = 0;
    int          pktTag = 0;

    nf_tx_arbiter #(.NUM_SRC(NUM_SRC), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk156     (clk156),
        .reset      (reset),
        .src_tdata  (src_tdata),
        .src_tkeep  (src_tkeep),
        .src_tlast  (src_tlast),
        .src_tvalid (src_tvalid),
        .src_tready (src_tready),
        .tx_tdata   (tx_tdata),
        .tx_tkeep   (tx_tkeep),
        .tx_tlast   (tx_tlast),
        .tx_tuser   (tx_tuser),
        .tx_tvalid  (tx_tvalid),
        .tx_tready  (tx_tready),
        .grant      (grant),
        .pkt_cnt    (pkt_cnt),
        .abort_cnt  (abort_cnt)
    );

    always #5 clk156 = ~clk156;

    // MAC side: either always ready or toggling every cycle.
    always @(posedge clk156) begin
        #1;
        tx_tready = toggleMode ? ~tx_tready : 1'b1;
    end

    // Source models: advance on the handshake seen at the previous negedge, honour per-beat stalls.
    always @(posedge clk156) begin
        srcBeat_t junk;
        #1;
        if (srcAcc[0] && q0.size() > 0) begin
            junk = q0.pop_front();
            popCnt0++;
            wait0 = 0;
        end else if (q0.size() > 0 && wait0 < q0[0].stall) begin
            wait0++;
        end else if (q0.size() == 0) begin
            wait0 = 0;
        end
        if (srcAcc[1] && q1.size() > 0) begin
            junk = q1.pop_front();
            wait1 = 0;
        end else if (q1.size() > 0 && wait1 < q1[0].stall) begin
            wait1++;
        end else if (q1.size() == 0) begin
            wait1 = 0;
        end
        src_tvalid = '0;
        src_tdata  = '0;
        src_tkeep  = '0;
        src_tlast  = '0;
        if (q0.size() > 0 && wait0 >= q0[0].stall) begin
            src_tvalid[0]    = 1'b1;
            src_tdata[63:0]  = q0[0].data;
            src_tkeep[7:0]   = q0[0].keep;
            src_tlast[0]     = q0[0].last;
        end
        if (q1.size() > 0 && wait1 >= q1[0].stall) begin
            src_tvalid[1]    = 1'b1;
            src_tdata[127:64] = q1[0].data;
            src_tkeep[15:8]  = q1[0].keep;
            src_tlast[1]     = q1[0].last;
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Queue one packet on a source and push the beats the MAC should see from it.
    task automatic applyStimulus(input int src, input int nBeats, input int stallAt, input int stallLen,
                                 input int nExp, input int gapFirst, input int gapStall, input bit doAbort);
        srcBeat_t b;
        expBeat_t e;
        for (int i = 0; i < nBeats; i++) begin
            b.data  = {4'hA, 4'(src), 8'(pktTag), 40'h0123456789, 8'(i)};
            b.keep  = (i == nBeats - 1) ? 8'h0F : 8'hFF;
            b.last  = (i == nBeats - 1);
            b.stall = (i == stallAt) ? stallLen : 0;
            if (src == 0) q0.push_back(b);
            else          q1.push_back(b);
            if (i < nExp) begin
                e.data  = b.data;
                e.keep  = b.keep;
                e.last  = b.last;
                e.user  = 1'b0;
                e.grant = 2'b01 << src;
                e.gap   = (i == 0) ? gapFirst : ((i == stallAt) ? gapStall : -1);
                expQ.push_back(e);
            end
        end
        if (doAbort) begin
            e.data  = 64'h0;
            e.keep  = 8'h01;
            e.last  = 1'b1;
            e.user  = 1'b1;
            e.grant = 2'b01 << src;
            e.gap   = -1;
            expQ.push_back(e);
            expAbort = (expAbort == 16'hFFFF) ? expAbort : expAbort + 1;
        end else if (nExp == nBeats) begin
            expPkt[src]++;
        end
        pktTag++;
    endtask

    task automatic waitDone(input int maxCyc);
        int n = 0;
        while (n < maxCyc && !(q0.size() == 0 && q1.size() == 0 && expQ.size() == 0 &&
                               grant == '0 && !tx_tvalid)) begin
            @(posedge clk156);
            #2;
            n++;
        end
        checkOutput("done_in_time", 128'(n < maxCyc), 128'(1));
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, "_pkt_cnt0"}, 128'(pkt_cnt[31:0]), 128'(expPkt[0]));
        checkOutput({tag, "_pkt_cnt1"}, 128'(pkt_cnt[63:32]), 128'(expPkt[1]));
        checkOutput({tag, "_abort_cnt"}, 128'(abort_cnt), 128'(expAbort));
    endtask

    initial begin
        expPkt[0] = 0;
        expPkt[1] = 0;
        fork
            begin
                int          idleCnt = 0;
                bit          heldValid = 1'b0;
                logic [73:0] heldBeat = '0;
                expBeat_t    e;
                while (!stimDone) begin
                    @(negedge clk156);
                    srcAcc = src_tvalid & src_tready;
                    if (reset) begin
                        heldValid = 1'b0;
                        idleCnt   = 0;
                    end else begin
                        if (heldValid && tx_tvalid)
                            checkOutput("held_stable", 128'({tx_tdata, tx_tkeep, tx_tlast, tx_tuser}),
                                        128'(heldBeat));
                        if (tx_tvalid && tx_tready) begin
                            if (expQ.size() == 0) begin
                                checkOutput("unexpected_beat", 128'({tx_tdata, tx_tkeep, tx_tlast, tx_tuser}),
                                            128'(0) - 128'(1));
                            end else begin
                                e = expQ.pop_front();
                                checkOutput("tx_beat",
                                            128'({tx_tdata, tx_tkeep, tx_tlast, tx_tuser, grant}),
                                            128'({e.data, e.keep, e.last, e.user, e.grant}));
                                if (e.gap >= 0) checkOutput("gap", 128'(idleCnt), 128'(e.gap));
                            end
                            idleCnt = 0;
                        end else begin
                            idleCnt++;
                        end
                        heldValid = tx_tvalid && !tx_tready;
                        heldBeat  = {tx_tdata, tx_tkeep, tx_tlast, tx_tuser};
                    end
                end
            end
            begin
                int base;
                int n;
                repeat (3) @(posedge clk156);
                #2;
                checkOutput("reset_idle", 128'({tx_tvalid, grant, src_tready}), 128'(0));
                checkCounters("reset");
                reset = 1'b0;

                $display("[TB] single source, three back-to-back packets");
                applyStimulus(0, 11, -1, 0, 11, -1, -1, 1'b0);
                applyStimulus(0, 11, -1, 0, 11, 1, -1, 1'b0);
                applyStimulus(0, 11, -1, 0, 11, 1, -1, 1'b0);
                waitDone(300);
                checkCounters("single");

                // rr_ptr points at src1 after the src0 packets, so src1 wins the first round.
                $display("[TB] both sources always valid");
                for (int p = 0; p < 4; p++) begin
                    applyStimulus(1, 5, -1, 0, 5, (p == 0) ? -1 : 1, -1, 1'b0);
                    applyStimulus(0, 5, -1, 0, 5, 1, -1, 1'b0);
                end
                waitDone(500);
                checkCounters("rr");

                $display("[TB] toggling tx_tready");
                toggleMode = 1'b1;
                applyStimulus(0, 11, -1, 0, 11, -1, -1, 1'b0);
                waitDone(300);
                toggleMode = 1'b0;
                checkCounters("toggle");

                $display("[TB] stall one cycle short of timeout");
                applyStimulus(0, 11, 4, TIMEOUT - 1, 11, -1, TIMEOUT - 1, 1'b0);
                waitDone(300);
                checkCounters("stall15");

                $display("[TB] stall to timeout, abort and drain");
                applyStimulus(0, 8, 3, 20, 3, -1, -1, 1'b1);
                applyStimulus(1, 4, 0, 10, 4, -1, -1, 1'b0);
                waitDone(300);
                checkCounters("abort");

                $display("[TB] reset mid-packet");
                base = popCnt0;
                applyStimulus(0, 11, -1, 0, 4, -1, -1, 1'b0);
                n = 0;
                while (popCnt0 < base + 4 && n < 100) begin
                    @(posedge clk156);
                    #2;
                    n++;
                end
                checkOutput("reach_beat5", 128'(n < 100), 128'(1));
                reset = 1'b1;
                q0.delete();
                expPkt[0] = 0;
                expPkt[1] = 0;
                expAbort  = 0;
                @(posedge clk156);
                #2;
                reset = 1'b0;
                checkOutput("post_reset_idle", 128'({tx_tvalid, grant, src_tready}), 128'(0));
                checkCounters("post_reset");
                applyStimulus(1, 4, -1, 0, 4, -1, -1, 1'b0);
                waitDone(200);
                checkCounters("after_reset");

                $display("[TB] abort counter saturation");
                force dut.abortCnt_q = 16'hFFFD;
                @(posedge clk156);
                #2;
                release dut.abortCnt_q;
                expAbort = 16'hFFFD;
                for (int k = 0; k < 3; k++) begin
                    applyStimulus(0, 3, 1, 20, 1, -1, -1, 1'b1);
                    waitDone(200);
                    checkCounters("sat");
                end
                stimDone = 1'b1;
            end
        join
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
